// File: rtl/video_vram_arbiter.sv
// video_vram_arbiter: shares the PPU VRAM bus between render fetches (priority) and CPU $2007 accesses
module video_vram_arbiter #(
  parameter int               P_addr_width = 14,
  parameter int               P_data_width = 8,
  parameter logic [5:0]       P_pal_base   = 6'h3F
) (
  input  logic                    I_vid_clock,
  input  logic                    I_reset_n,
  input  logic                    I_clk_rise,
  input  logic                    I_is_rendering,
  input  logic                    I_ren_req,
  input  logic [P_addr_width-1:0] I_ren_addr,
  output logic [P_data_width-1:0] O_ren_data,
  output logic                    O_ren_valid,
  input  logic                    I_cpu_rd,
  input  logic                    I_cpu_wr,
  input  logic [P_data_width-1:0] I_cpu_wdata,
  input  logic [P_addr_width-1:0] I_vaddr,
  output logic [P_data_width-1:0] O_cpu_rdata,
  output logic                    O_cpu_busy,
  output logic                    O_v_incr,
  output logic                    O_v_incr_hv,
  output logic [P_addr_width-1:0] O_mem_addr,
  output logic                    O_mem_rd,
  output logic                    O_mem_wr,
  output logic [P_data_width-1:0] O_mem_wdata,
  input  logic [P_data_width-1:0] I_mem_rdata
);
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_A, S_RD_D, S_PAL_A, S_PAL_D} state_e;
  localparam logic [P_addr_width-1:0] L_pal_mask = P_addr_width'('h2FFF);
  state_e                  state_q, state_d;
  logic                    pend_q, pend_d, kind_q, kind_d, ren_valid_q, ren_valid_d;
  logic [P_addr_width-1:0] addr_q, addr_d, cpu_addr;
  logic [P_data_width-1:0] wdata_q, wdata_d, buf_q, buf_d, rdata_q, rdata_d;
  logic                    cpu_rd_en, cpu_wr_en;
  always_ff @(posedge I_vid_clock or negedge I_reset_n) begin
    if (!I_reset_n) begin
      state_q     <= S_IDLE;
      pend_q      <= 1'b0;
      kind_q      <= 1'b0;
      ren_valid_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      buf_q       <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      kind_q      <= kind_d;
      ren_valid_q <= ren_valid_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      rdata_q     <= rdata_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    kind_d      = kind_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    rdata_d     = rdata_q;
    ren_valid_d = I_clk_rise ? (I_is_rendering & I_ren_req) : ren_valid_q;
    O_v_incr    = 1'b0;
    O_v_incr_hv = 1'b0;
    cpu_rd_en   = (state_q == S_RD_A) || (state_q == S_PAL_A);
    cpu_wr_en   = (state_q == S_WR);
    cpu_addr    = (state_q == S_PAL_A) ? (addr_q & L_pal_mask) : addr_q;
    // kind_q=1 marks a write; a simultaneous rd+wr is treated as a write
    if (!pend_q && (I_cpu_rd || I_cpu_wr)) begin
      pend_d  = 1'b1;
      kind_d  = I_cpu_wr;
      addr_d  = I_vaddr;
      wdata_d = I_cpu_wdata;
    end
    if (I_clk_rise) begin
      if (I_is_rendering) begin
        // render took the bus: abort any in-flight op, or retire a new request without a bus cycle
        if (state_q != S_IDLE) begin
          state_d = S_IDLE;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          O_v_incr_hv = 1'b1;
          pend_d      = 1'b0;
          rdata_d     = kind_q ? rdata_q : buf_q;
        end
      end else begin
        case (state_q)
          S_IDLE: if (pend_q) begin
            O_v_incr = 1'b1;
            state_d  = kind_q ? S_WR : S_RD_A;
          end
          S_WR: begin
            state_d = S_IDLE;
            pend_d  = 1'b0;
          end
          S_RD_A: state_d = (addr_q[P_addr_width-1:8] == P_pal_base) ? S_PAL_A : S_RD_D;
          S_RD_D: begin
            rdata_d = buf_q;
            buf_d   = I_mem_rdata;
            state_d = S_IDLE;
            pend_d  = 1'b0;
          end
          // palette data goes straight to the CPU; the mirrored nametable byte refills the buffer
          S_PAL_A: begin
            rdata_d = I_mem_rdata;
            state_d = S_PAL_D;
          end
          S_PAL_D: begin
            buf_d   = I_mem_rdata;
            state_d = S_IDLE;
            pend_d  = 1'b0;
          end
          default: state_d = S_IDLE;
        endcase
      end
    end
  end
  assign O_mem_addr  = I_is_rendering ? I_ren_addr : cpu_addr;
  assign O_mem_rd    = I_is_rendering ? I_ren_req : cpu_rd_en;
  assign O_mem_wr    = !I_is_rendering && cpu_wr_en;
  assign O_mem_wdata = O_mem_wr ? wdata_q : '0;
  assign O_ren_valid = ren_valid_q;
  assign O_ren_data  = ren_valid_q ? I_mem_rdata : '0;
  assign O_cpu_rdata = rdata_q;
  assign O_cpu_busy  = pend_q;
endmodule

// File: tb/tb_video_vram_arbiter.sv
// tb_video_vram_arbiter: scoreboard bench for the VRAM arbiter with a small VRAM model
module tb_video_vram_arbiter;
  logic        clk = 1'b0, rst_n = 1'b0, clk_rise = 1'b1, rendering = 1'b0;
  logic        ren_req = 1'b0, cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [13:0] ren_addr = '0, vaddr = '0;
  logic [7:0]  cpu_wdata = '0, mem_rdata = '0;
  logic [7:0]  ren_data, cpu_rdata, mem_wdata;
  logic        ren_valid, busy, v_incr, v_incr_hv, mem_rd, mem_wr;
  logic [13:0] mem_addr;
  logic [7:0]  mem [16384];
  logic [21:0] q_wr [$];
  logic        q_inc [$];
  logic [7:0]  q_rd [$];
  logic [7:0]  q_ren [$];
  logic        busy_prev = 1'b0;
  int          vectors = 0, miscompares = 0;

  video_vram_arbiter dut (
    .I_vid_clock(clk), .I_reset_n(rst_n), .I_clk_rise(clk_rise), .I_is_rendering(rendering),
    .I_ren_req(ren_req), .I_ren_addr(ren_addr), .O_ren_data(ren_data), .O_ren_valid(ren_valid),
    .I_cpu_rd(cpu_rd), .I_cpu_wr(cpu_wr), .I_cpu_wdata(cpu_wdata), .I_vaddr(vaddr),
    .O_cpu_rdata(cpu_rdata), .O_cpu_busy(busy), .O_v_incr(v_incr), .O_v_incr_hv(v_incr_hv),
    .O_mem_addr(mem_addr), .O_mem_rd(mem_rd), .O_mem_wr(mem_wr), .O_mem_wdata(mem_wdata),
    .I_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (clk_rise) begin
    if (mem_rd) mem_rdata <= mem[mem_addr];
    if (mem_wr) mem[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    if (mem_wr) begin
      chk("wr_expected", q_wr.size() != 0, 1);
      if (q_wr.size() != 0) chk("mem_wr_addr_data", {mem_addr, mem_wdata}, q_wr.pop_front());
    end
    if (v_incr || v_incr_hv) begin
      chk("incr_expected", q_inc.size() != 0, 1);
      if (q_inc.size() != 0) chk("incr_kind", {v_incr, v_incr_hv}, q_inc.pop_front() ? 2'b01 : 2'b10);
    end
    if (busy_prev && !busy) begin
      chk("done_expected", q_rd.size() != 0, 1);
      if (q_rd.size() != 0) chk("cpu_rdata", cpu_rdata, q_rd.pop_front());
    end
    if (ren_valid) begin
      chk("ren_expected", q_ren.size() != 0, 1);
      if (q_ren.size() != 0) chk("ren_data", ren_data, q_ren.pop_front());
    end
    if (mem_rd && mem_wr) chk("rd_wr_exclusive", {mem_rd, mem_wr}, 2'b10);
    if (rendering) chk("render_owns_bus", {mem_rd, mem_wr}, {ren_req, 1'b0});
    busy_prev = busy;
  end

  // issue one $2007 pulse; exp_hv selects which increment strobe is expected
  task automatic req(input logic rd, input logic wr, input logic [13:0] a, input logic [7:0] d,
                     input logic exp_hv, input logic [7:0] exp_rdata, input logic extra);
    if (wr && !rendering) q_wr.push_back({a, d});
    q_inc.push_back(exp_hv);
    q_rd.push_back(exp_rdata);
    @(posedge clk); #1;
    cpu_rd = rd; cpu_wr = wr; vaddr = a; cpu_wdata = d;
    @(posedge clk); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
    if (extra) begin
      cpu_wr = 1'b1; vaddr = 14'h2005; cpu_wdata = 8'hFF;
      @(posedge clk); #1;
      cpu_wr = 1'b0;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h2001] = 8'h11; mem[14'h3F05] = 8'h2C; mem[14'h2F05] = 8'h77; mem[14'h2400] = 8'h5A;
    #12;
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_incr", {v_incr, v_incr_hv}, 0);
    chk("rst_addr", mem_addr, 0);
    rst_n = 1'b1;
    req(0, 1, 14'h2000, 8'hA5, 0, 8'h00, 0); wait_idle();
    req(1, 0, 14'h2001, 8'h00, 0, 8'h00, 0); wait_idle();
    req(1, 0, 14'h2001, 8'h00, 0, 8'h11, 0); wait_idle();
    req(1, 0, 14'h3F05, 8'h00, 0, 8'h2C, 0); wait_idle();
    req(1, 0, 14'h2400, 8'h00, 0, 8'h77, 0); wait_idle();
    rendering = 1'b1;
    req(1, 0, 14'h2001, 8'h00, 1, 8'h5A, 0); wait_idle();
    req(0, 1, 14'h2006, 8'hEE, 1, 8'h5A, 0); wait_idle();
    q_ren.push_back(8'hA5);
    @(posedge clk); #1;
    ren_req = 1'b1; ren_addr = 14'h2000;
    #1;
    chk("ren_bus_addr", {mem_rd, mem_addr}, {1'b1, 14'h2000});
    @(posedge clk); #1;
    ren_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rendering = 1'b0;
    // render takes the bus while the CPU read sits in RD_A
    q_inc.push_back(0);
    q_rd.push_back(8'h5A);
    @(posedge clk); #1;
    cpu_rd = 1'b1; vaddr = 14'h2001;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
    @(posedge clk); #1;
    rendering = 1'b1;
    wait_idle();
    @(posedge clk); #1;
    rendering = 1'b0;
    req(1, 0, 14'h2400, 8'h00, 0, 8'h5A, 0); wait_idle();
    req(1, 1, 14'h2002, 8'h96, 0, 8'h5A, 1); wait_idle();
    chk("write_wins_mem", mem[14'h2002], 8'h96);
    chk("ignored_pulse_mem", mem[14'h2005], 8'h00);
    req(0, 1, 14'h2003, 8'h33, 0, 8'h00, 0);
    for (int i = 0; i < 10 && !mem_wr; i++) @(negedge clk);
    chk("wr_reached", mem_wr, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_mem_wr", mem_wr, 0);
    chk("rst_mid_wr_busy", busy, 0);
    chk("rst_mid_wr_rdata", cpu_rdata, 0);
    chk("rst_mid_wr_addr", mem_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("wr_queue_drained", q_wr.size(), 0);
    chk("incr_queue_drained", q_inc.size(), 0);
    chk("rd_queue_drained", q_rd.size(), 0);
    chk("ren_queue_drained", q_ren.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
